// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM encoding, the pipeline-control bundle and the load-use detector.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic branch_taken;
        logic id_ex_hold;
    } ctrl_t;

    // Front end frozen, IF/ID and ID/EX both loaded with NOPs.
    localparam ctrl_t NOP_CTRL = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        if_id_flush:  1'b1,
        id_ex_bubble: 1'b1,
        branch_taken: 1'b0,
        id_ex_hold:   1'b0
    };

    localparam ctrl_t RUN_CTRL = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        if_id_flush:  1'b0,
        id_ex_bubble: 1'b0,
        branch_taken: 1'b0,
        id_ex_hold:   1'b0
    };

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic       uses_rs1,
        input logic [4:0] rs1,
        input logic       uses_rs2,
        input logic [4:0] rs2
    );
        return memread && (rd != REG_X0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes,
// front-end freeze during multi-cycle EX ops, plus perf counters and timeout flag.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             ex_md_done,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             branch_taken,
    output logic             id_ex_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             md_timeout,
    output logic             fsm_state
);

    localparam int TMR_W = $clog2(MD_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             timeout_set;
    logic             hit;
    logic             flush_evt;
    ctrl_t            ctrl;

    assign hit = load_use_hit(ex_memread, ex_rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            timer      <= '0;
            md_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (timeout_set) begin
                md_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl        = RUN_CTRL;
        state_nxt   = state;
        timer_nxt   = timer;
        timeout_set = 1'b0;
        flush_evt   = 1'b0;

        if (state == MD_BUSY) begin
            // Branch and load-use requests are masked while the MD unit owns EX.
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_hold  = 1'b1;
            timer_nxt        = timer + TMR_W'(1);
            if (ex_md_done) begin
                state_nxt = RUN;
            end else if (timer_nxt == TMR_W'(MD_TIMEOUT)) begin
                state_nxt   = RUN;
                timeout_set = 1'b1;
            end
        end else if (ex_branch_taken) begin
            ctrl.branch_taken = 1'b1;
            ctrl.if_id_flush  = 1'b1;
            flush_evt         = 1'b1;
        end else begin
            // A start that completes in the same cycle never needs a freeze.
            if (ex_md_start && !ex_md_done) begin
                state_nxt = MD_BUSY;
                timer_nxt = '0;
            end
            if (hit) begin
                ctrl.pc_write     = 1'b0;
                ctrl.if_id_write  = 1'b0;
                ctrl.id_ex_bubble = 1'b1;
            end
        end

        if (!reset_n) begin
            ctrl = NOP_CTRL;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign branch_taken = ctrl.branch_taken;
    assign id_ex_hold   = ctrl.id_ex_hold;
    assign fsm_state    = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (!ctrl.pc_write),
        .clr     (cnt_clear),
        .count   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush_evt),
        .clr     (cnt_clear),
        .count   (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues one stimulus per cycle and
// queues the model's expected outputs; a monitor compares on the falling edge.
module tb_hazard_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 8;
    localparam int EW  = 7 + 2 * CW;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_memread;
    logic          ex_branch_taken, ex_md_start, ex_md_done, cnt_clear;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic          branch_taken, id_ex_hold, md_timeout, fsm_state;
    logic [CW-1:0] stall_cycles, flush_count;

    hazard_ctrl #(.CNT_W(CW), .MD_TIMEOUT(TMO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .ex_md_done      (ex_md_done),
        .cnt_clear       (cnt_clear),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .branch_taken    (branch_taken),
        .id_ex_hold      (id_ex_hold),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .md_timeout      (md_timeout),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic       start;
        logic       done;
        logic       clr;
    } stim_t;

    // ---------------- scoreboard + model state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int m_busy_len = 0;   // 0: not frozen, k: k-th cycle of the multi-cycle op
    int m_stall    = 0;
    int m_flush    = 0;
    bit m_sticky   = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle();
        s.rs1     = 5'($urandom_range(0, 3));
        s.rs2     = 5'($urandom_range(0, 3));
        s.rd      = 5'($urandom_range(0, 3));
        s.u1      = ($urandom_range(0, 3) != 0);
        s.u2      = ($urandom_range(0, 1) != 0);
        s.memread = ($urandom_range(0, 2) == 0);
        s.start   = !s.memread && ($urandom_range(0, 7) == 0);
        s.br      = ($urandom_range(0, 5) == 0);
        s.done    = ($urandom_range(0, 3) == 0);
        s.clr     = ($urandom_range(0, 29) == 0);
        s.rst_n   = ($urandom_range(0, 119) != 0);
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input stim_t s);
        logic pc, ifw, fl, bub, br, hold;
        bit   hit;
        @(posedge clock);
        #1;
        reset_n         = s.rst_n;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_uses_rs1     = s.u1;
        id_uses_rs2     = s.u2;
        ex_memread      = s.memread;
        ex_rd           = s.rd;
        ex_branch_taken = s.br;
        ex_md_start     = s.start;
        ex_md_done      = s.done;
        cnt_clear       = s.clr;
        cyc++;

        hit = s.memread && (s.rd != 0) &&
              ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
        pc = 1; ifw = 1; fl = 0; bub = 0; br = 0; hold = 0;
        if (!s.rst_n) begin
            m_stall = 0; m_flush = 0; m_sticky = 0; m_busy_len = 0;
            pc = 0; ifw = 0; fl = 1; bub = 1;
        end else if (m_busy_len > 0) begin
            pc = 0; ifw = 0; hold = 1;
        end else if (s.br) begin
            br = 1; fl = 1;
        end else if (hit) begin
            pc = 0; ifw = 0; bub = 1;
        end
        exp_q.push_back({pc, ifw, fl, bub, br, hold, m_sticky, CW'(m_stall), CW'(m_flush)});

        if (s.rst_n) begin
            if (m_busy_len > 0) begin
                if (s.done) m_busy_len = 0;
                else if (m_busy_len == TMO) begin
                    m_busy_len = 0;
                    m_sticky   = 1;
                end else m_busy_len++;
            end else if (!s.br && s.start && !s.done) begin
                m_busy_len = 1;
            end
            if (s.clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (!pc && m_stall < CNT_MAX) m_stall++;
                if (br && m_flush < CNT_MAX) m_flush++;
            end
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(idle());
    endtask

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_e, mon_a;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {pc_write, if_id_write, if_id_flush, id_ex_bubble, branch_taken,
                     id_ex_hold, md_timeout, stall_cycles, flush_count};
            n_checks++;
            if (mon_a === mon_e) n_pass++;
            else $display("FAIL outputs cycle %0d: act=%h exp=%h (pc,ifw,flush,bub,br,hold,tmo,stall,flush_cnt)",
                          cyc, mon_a, mon_e);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        reset_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memread = 0;
        ex_branch_taken = 0; ex_md_start = 0; ex_md_done = 0; cnt_clear = 0;

        s = idle(); s.rst_n = 0;
        step(s); step(s);
        idle_n(1);

        // load x5 in EX, ID reads x5 as rs1
        s = idle(); s.memread = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        step(s);
        idle_n(1);
        // load x0 / unused rs2 match: no stall
        s = idle(); s.memread = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; s.rs2 = 0; s.u2 = 1;
        step(s);
        s = idle(); s.memread = 1; s.rd = 7; s.rs2 = 7; s.u2 = 0; s.rs1 = 3; s.u1 = 1;
        step(s);
        // branch wins over a concurrent load-use hit
        s = idle(); s.br = 1; s.memread = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
        step(s);
        idle_n(1);
        // multi-cycle op, done on the 4th busy cycle
        s = idle(); s.start = 1; step(s);
        idle_n(3);
        s = idle(); s.done = 1; step(s);
        idle_n(2);
        // same-cycle start+done
        s = idle(); s.start = 1; s.done = 1; step(s);
        idle_n(1);
        // timeout path, flag stays set
        s = idle(); s.start = 1; step(s);
        idle_n(TMO + 4);
        // clear, then saturate both counters
        s = idle(); s.clr = 1; step(s);
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.memread = 1; s.rd = 4; s.rs2 = 4; s.u2 = 1; step(s);
        end
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.br = 1; step(s);
        end
        idle_n(1);
        // reset in the middle of a multi-cycle op
        s = idle(); s.start = 1; step(s);
        idle_n(2);
        s = idle(); s.rst_n = 0; step(s); step(s);
        idle_n(3);

        for (int i = 0; i < 600; i++) step(rand_stim());
        idle_n(2);

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: act=%0d pending exp=0 pending", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
